// File: rtl/rfile_mp_sb_if.sv
// Register file bus: write ports, read ports and scoreboard control/status.
// Multi-port fields are flat vectors, port k at [k*W +: W].
interface rfile_mp_sb_if #(
    parameter int WIDTH_I     = 32,
    parameter int ADDR_RFILE  = 5,
    parameter int DEPTH_RFILE = 2**ADDR_RFILE,
    parameter int NR          = 2,
    parameter int NW          = 1
);
    logic [NW-1:0]            w_en;
    logic [NW*ADDR_RFILE-1:0] w_addr;
    logic [NW*WIDTH_I-1:0]    w_data;
    logic [NR*ADDR_RFILE-1:0] r_addr;
    logic [NR*WIDTH_I-1:0]    r_data;
    logic [NR-1:0]            r_busy;
    logic                     sb_set_en;
    logic [ADDR_RFILE-1:0]    sb_set_addr;
    logic [DEPTH_RFILE-1:0]   busy;

    modport master (
        output w_en, w_addr, w_data, r_addr, sb_set_en, sb_set_addr,
        input  r_data, r_busy, busy
    );
    modport slave (
        input  w_en, w_addr, w_data, r_addr, sb_set_en, sb_set_addr,
        output r_data, r_busy, busy
    );
endinterface

// File: rtl/rfile_mp_sb.sv
// Multi-port register file with write-to-read bypass and a per-register busy
// scoreboard used by decode to stall on RAW hazards.

// One read port: zero-register and same-cycle bypass overrides on the array value.
module rfile_mp_sb_rd #(
    parameter int WIDTH_I    = 32,
    parameter int ADDR_RFILE = 5,
    parameter int NW         = 1,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           rst_n,
    input  logic [ADDR_RFILE-1:0]          r_addr,
    input  logic [WIDTH_I-1:0]             reg_data,
    input  logic                           reg_busy,
    input  logic [NW-1:0]                  w_en,
    input  logic [NW-1:0][ADDR_RFILE-1:0]  w_addr,
    input  logic [NW-1:0][WIDTH_I-1:0]     w_data,
    output logic [WIDTH_I-1:0]             r_data,
    output logic                           r_busy
);
    always_comb begin
        r_data = reg_data;
        r_busy = reg_busy;
        // Ascending scan so the highest-index matching port wins.
        if (BYPASS != 0 && rst_n) begin
            for (int j = 0; j < NW; j++) begin
                if (w_en[j] && w_addr[j] == r_addr) begin
                    r_data = w_data[j];
                    r_busy = 1'b0;
                end
            end
        end
        if (ZERO_REG != 0 && r_addr == '0) begin
            r_data = '0;
            r_busy = 1'b0;
        end
    end
endmodule

module rfile_mp_sb #(
    parameter int WIDTH_I     = 32,
    parameter int ADDR_RFILE  = 5,
    parameter int DEPTH_RFILE = 2**ADDR_RFILE,
    parameter int NR          = 2,
    parameter int NW          = 1,
    parameter int ZERO_REG    = 1,
    parameter int BYPASS      = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    rfile_mp_sb_if.slave rf
);
    logic [DEPTH_RFILE-1:0][WIDTH_I-1:0] regs;
    logic [DEPTH_RFILE-1:0]              busy_q, busy_nxt;
    logic [NW-1:0][ADDR_RFILE-1:0]       wa;
    logic [NW-1:0][WIDTH_I-1:0]          wd;
    logic [NR-1:0][ADDR_RFILE-1:0]       ra;
    logic [NR-1:0][WIDTH_I-1:0]          rd;
    logic [NR-1:0]                       rb;

    for (genvar j = 0; j < NW; j++) begin : g_wr
        assign wa[j] = rf.w_addr[j*ADDR_RFILE +: ADDR_RFILE];
        assign wd[j] = rf.w_data[j*WIDTH_I +: WIDTH_I];
    end

    // Set beats clear: a set in the same cycle is a newer producer.
    always_comb begin
        busy_nxt = busy_q;
        for (int a = 0; a < DEPTH_RFILE; a++) begin
            for (int j = 0; j < NW; j++) begin
                if (rf.w_en[j] && wa[j] == ADDR_RFILE'(a)) busy_nxt[a] = 1'b0;
            end
            if (rf.sb_set_en && rf.sb_set_addr == ADDR_RFILE'(a)) busy_nxt[a] = 1'b1;
        end
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs   <= '0;
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
            for (int j = 0; j < NW; j++) begin
                if (rf.w_en[j] && !(ZERO_REG != 0 && wa[j] == '0)) regs[wa[j]] <= wd[j];
            end
        end
    end

    assign rf.busy = busy_q;

    for (genvar k = 0; k < NR; k++) begin : g_rd
        assign ra[k] = rf.r_addr[k*ADDR_RFILE +: ADDR_RFILE];
        rfile_mp_sb_rd #(
            .WIDTH_I(WIDTH_I), .ADDR_RFILE(ADDR_RFILE), .NW(NW),
            .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rd (
            .rst_n    (rst_n),
            .r_addr   (ra[k]),
            .reg_data (regs[ra[k]]),
            .reg_busy (busy_q[ra[k]]),
            .w_en     (rf.w_en),
            .w_addr   (wa),
            .w_data   (wd),
            .r_data   (rd[k]),
            .r_busy   (rb[k])
        );
        assign rf.r_data[k*WIDTH_I +: WIDTH_I] = rd[k];
        assign rf.r_busy[k]                    = rb[k];
    end
endmodule

// File: tb/tb_rfile_mp_sb.sv
// Directed bench: a bypassing and a non-bypassing instance share one stimulus stream.
module tb_rfile_mp_sb;
    localparam int W = 32;
    localparam int A = 5;
    localparam int D = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rfile_mp_sb_if #(.WIDTH_I(W), .ADDR_RFILE(A), .NR(2), .NW(2)) ifa ();
    rfile_mp_sb_if #(.WIDTH_I(W), .ADDR_RFILE(A), .NR(2), .NW(2)) ifb ();

    assign ifb.w_en        = ifa.w_en;
    assign ifb.w_addr      = ifa.w_addr;
    assign ifb.w_data      = ifa.w_data;
    assign ifb.r_addr      = ifa.r_addr;
    assign ifb.sb_set_en   = ifa.sb_set_en;
    assign ifb.sb_set_addr = ifa.sb_set_addr;

    rfile_mp_sb #(.WIDTH_I(W), .ADDR_RFILE(A), .NR(2), .NW(2), .ZERO_REG(1), .BYPASS(1))
        dut_byp (.clk(clk), .rst_n(rst_n), .rf(ifa));
    rfile_mp_sb #(.WIDTH_I(W), .ADDR_RFILE(A), .NR(2), .NW(2), .ZERO_REG(1), .BYPASS(0))
        dut_nob (.clk(clk), .rst_n(rst_n), .rf(ifb));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifa.w_en      = '0;
        ifa.sb_set_en = 1'b0;
    endtask

    task automatic wr(input int p, input logic [A-1:0] addr, input logic [W-1:0] data);
        ifa.w_en[p]           = 1'b1;
        ifa.w_addr[p*A +: A]  = addr;
        ifa.w_data[p*W +: W]  = data;
    endtask

    task automatic rd_addr(input int p, input logic [A-1:0] addr);
        ifa.r_addr[p*A +: A] = addr;
    endtask

    initial begin
        rst_n           = 1'b0;
        ifa.w_en        = '0;
        ifa.w_addr      = '0;
        ifa.w_data      = '0;
        ifa.r_addr      = '0;
        ifa.sb_set_en   = 1'b0;
        ifa.sb_set_addr = '0;
        tick();
        tick();
        check("rst_busy_byp", 64'(ifa.busy), 64'h0);
        check("rst_busy_nob", 64'(ifb.busy), 64'h0);
        rst_n = 1'b1;

        // 1: every register reads 0 and not busy after reset
        for (int a = 1; a < D; a++) begin
            rd_addr(0, A'(a));
            rd_addr(1, A'(D - a));
            #1;
            check("rst_rd_byp", 64'(ifa.r_data), 64'h0);
            check("rst_rd_nob", 64'(ifb.r_data), 64'h0);
            check("rst_rbusy",  64'({ifa.r_busy, ifb.r_busy}), 64'h0);
        end

        // 2: write r5 with same-cycle read
        rd_addr(0, 5'd5);
        rd_addr(1, 5'd6);
        wr(0, 5'd5, 32'hDEAD_BEEF);
        #1;
        check("byp_same_cycle",  64'(ifa.r_data[0 +: W]), 64'hDEAD_BEEF);
        check("nobyp_same_cyc",  64'(ifb.r_data[0 +: W]), 64'h0);
        check("byp_other_port",  64'(ifa.r_data[W +: W]), 64'h0);
        tick();
        idle();
        #1;
        check("nobyp_next_cyc",  64'(ifb.r_data[0 +: W]), 64'hDEAD_BEEF);
        check("byp_next_cyc",    64'(ifa.r_data[0 +: W]), 64'hDEAD_BEEF);

        // 3: r0 is hardwired zero and never busy
        rd_addr(0, 5'd0);
        wr(0, 5'd0, 32'h1234);
        ifa.sb_set_en   = 1'b1;
        ifa.sb_set_addr = 5'd0;
        #1;
        check("r0_bypass_blocked", 64'(ifa.r_data[0 +: W]), 64'h0);
        check("r0_rbusy_same",     64'(ifa.r_busy[0]), 64'h0);
        tick();
        idle();
        #1;
        check("r0_after_write",    64'(ifa.r_data[0 +: W]), 64'h0);
        check("r0_after_write_nb", 64'(ifb.r_data[0 +: W]), 64'h0);
        check("r0_busy_bit",       64'(ifa.busy[0]), 64'h0);

        // 4: both ports write r7; port 1 wins
        rd_addr(1, 5'd7);
        wr(0, 5'd7, 32'h11);
        wr(1, 5'd7, 32'h22);
        #1;
        check("dual_wr_bypass", 64'(ifa.r_data[W +: W]), 64'h22);
        tick();
        idle();
        #1;
        check("dual_wr_byp_arr", 64'(ifa.r_data[W +: W]), 64'h22);
        check("dual_wr_nob_arr", 64'(ifb.r_data[W +: W]), 64'h22);

        // 5: scoreboard set / set+clear / clear
        rd_addr(0, 5'd9);
        ifa.sb_set_en   = 1'b1;
        ifa.sb_set_addr = 5'd9;
        #1;
        check("sb_pre_set_rbusy", 64'(ifa.r_busy[0]), 64'h0);
        tick();
        idle();
        #1;
        check("sb_set_vec",      64'(ifa.busy), 64'h0000_0200);
        check("sb_set_rbusy_b",  64'(ifa.r_busy[0]), 64'h1);
        check("sb_set_rbusy_nb", 64'(ifb.r_busy[0]), 64'h1);
        wr(0, 5'd9, 32'h99);
        ifa.sb_set_en   = 1'b1;
        ifa.sb_set_addr = 5'd9;
        #1;
        check("sb_setclr_rbusy_b",  64'(ifa.r_busy[0]), 64'h0);
        check("sb_setclr_rbusy_nb", 64'(ifb.r_busy[0]), 64'h1);
        tick();
        idle();
        #1;
        check("sb_set_wins", 64'(ifa.busy[9]), 64'h1);
        check("sb_set_wins_nb", 64'(ifb.busy[9]), 64'h1);
        wr(1, 5'd9, 32'h9A);
        #1;
        check("sb_clr_rbusy_b",  64'(ifa.r_busy[0]), 64'h0);
        check("sb_clr_rbusy_nb", 64'(ifb.r_busy[0]), 64'h1);
        check("sb_clr_data_b",   64'(ifa.r_data[0 +: W]), 64'h9A);
        check("sb_clr_data_nb",  64'(ifb.r_data[0 +: W]), 64'h99);
        tick();
        idle();
        #1;
        check("sb_clr_vec",   64'(ifa.busy), 64'h0);
        check("sb_clr_rbusy", 64'({ifa.r_busy[0], ifb.r_busy[0]}), 64'h0);

        // 6: reset overrides a concurrent write and set
        rd_addr(0, 5'd3);
        wr(0, 5'd3, 32'hAA);
        tick();
        idle();
        ifa.sb_set_en   = 1'b1;
        ifa.sb_set_addr = 5'd4;
        tick();
        idle();
        #1;
        check("pre_rst_data", 64'(ifb.r_data[0 +: W]), 64'hAA);
        check("pre_rst_busy", 64'(ifa.busy), 64'h0000_0010);
        rst_n = 1'b0;
        wr(0, 5'd3, 32'hBB);
        ifa.sb_set_en   = 1'b1;
        ifa.sb_set_addr = 5'd3;
        tick();
        #1;
        check("rst_wr_data_b",  64'(ifa.r_data[0 +: W]), 64'h0);
        check("rst_wr_data_nb", 64'(ifb.r_data[0 +: W]), 64'h0);
        check("rst_wr_busy",    64'({ifa.busy, ifb.busy}), 64'h0);
        check("rst_wr_rbusy",   64'({ifa.r_busy, ifb.r_busy}), 64'h0);
        idle();
        rst_n = 1'b1;
        #1;
        check("post_rst_data", 64'(ifa.r_data[0 +: W]), 64'h0);
        tick();
        check("post_rst_data2", 64'(ifb.r_data[0 +: W]), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
